// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int CNT_W = 16);
  logic if_req, if_done, d_req, d_we, d_done;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic stall_if, stall_mem, err;
  logic [CNT_W-1:0] fetch_cnt, data_cnt;
  modport slave (
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, err, fetch_cnt, data_cnt
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
    input stall_if, stall_mem, err, fetch_cnt, data_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/MEM sharing of one variable-latency memory port with timeout abort
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] fetch_cnt, data_cnt;
  logic last_data, if_ok, d_ok, grant_if, grant_d, busy, fin, tout;
  assign bus.mem_req = busy;
  assign bus.stall_if = bus.if_req & ~bus.if_done;
  assign bus.stall_mem = bus.d_req & ~bus.d_done;
  assign bus.fetch_cnt = fetch_cnt;
  assign bus.data_cnt = data_cnt;
  always_comb begin
    if_ok = bus.if_req & ~bus.if_done;
    d_ok = bus.d_req & ~bus.d_done;
    grant_if = if_ok & (~d_ok | last_data);
    grant_d = d_ok & ~grant_if;
    busy = state != IDLE;
    fin = busy & bus.mem_ready;
    tout = busy & ~bus.mem_ready & (wait_cnt == WW'(TIMEOUT - 1));
    state_nxt = busy ? ((fin | tout) ? IDLE : state) : (grant_if ? FETCH : grant_d ? DATA : IDLE);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      last_data <= 1'b1;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.if_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata <= '0;
      bus.err <= 1'b0;
      fetch_cnt <= '0;
      data_cnt <= '0;
    end else begin
      bus.if_done <= (fin | tout) && state == FETCH;
      bus.d_done <= (fin | tout) && state == DATA;
      if (!busy && (grant_if || grant_d)) begin
        wait_cnt <= '0;
        last_data <= grant_d;
        bus.mem_we <= grant_d & bus.d_we;
        bus.mem_addr <= grant_d ? bus.d_addr : bus.if_addr;
        bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
      end else if (busy && !fin)
        wait_cnt <= wait_cnt + 1'b1;
      // an aborted access returns zero data and leaves the counters alone
      if ((fin || tout) && state == FETCH)
        bus.if_rdata <= fin ? bus.mem_rdata : '0;
      if ((fin || tout) && state == DATA)
        bus.d_rdata <= (fin && !bus.mem_we) ? bus.mem_rdata : '0;
      if (fin && state == FETCH)
        fetch_cnt <= fetch_cnt + 1'b1;
      if (fin && state == DATA)
        data_cnt <= data_cnt + 1'b1;
      if (tout)
        bus.err <= 1'b1;
    end
  end
endmodule
